// File: rtl/m_axi_lite_cmd.sv
// -----------------------------------------------------------------------------
// NVP_v1_constants
//   Shared widths of the NVP_v1 control-register AXI4-Lite bus.
//
// m_axi_lite_cmd
//   Single-outstanding AXI4-Lite master. It takes one command at a time from a
//   valid/ready command port and turns it into an AXI-Lite write (AW + W, then B)
//   or read (AR, then R). The result goes out on a valid/ready response port.
//   Sequencers and harnesses use it to program and read back NVP_v1 control
//   registers without handling the AXI channel handshakes themselves.
//
//   The data width must be 32 or 64.
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESET      clock; synchronous active-high reset
//   CMD_VALID/READY               command handshake
//   CMD_WRITE/ADDR/WDATA/WSTRB    command payload (1 = write)
//   RSP_VALID/READY               response handshake
//   RSP_RDATA/RESP/WRITE          result (RDATA is 0 for writes)
//   ERR_COUNT                     saturating count of non-OKAY responses
//   M_AXI_AW*/W*/B*/AR*/R*        AXI4-Lite master channels
// -----------------------------------------------------------------------------
package NVP_v1_constants;
  localparam int CONTROL_AXI_DATA_WIDTH = 32;
  localparam int CONTROL_AXI_ADDR_WIDTH = 12;
endpackage

module m_axi_lite_cmd #(
  parameter int C_M_AXI_DATA_WIDTH = NVP_v1_constants::CONTROL_AXI_DATA_WIDTH,
  parameter int C_M_AXI_ADDR_WIDTH = NVP_v1_constants::CONTROL_AXI_ADDR_WIDTH
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  // command port
  input  logic                            CMD_VALID,
  output logic                            CMD_READY,
  input  logic                            CMD_WRITE,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] CMD_WSTRB,
  // response port
  output logic                            RSP_VALID,
  input  logic                            RSP_READY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]                      RSP_RESP,
  output logic                            RSP_WRITE,
  output logic [15:0]                     ERR_COUNT,
  // write address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  // write data channel
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  // write response channel
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  // read address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  // read data channel
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_DATA,
    S_RSP
  } state_e;

  state_e          state_q,     state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            cmd_write_q, cmd_write_d;
  logic            awvalid_q,   awvalid_d;
  logic            wvalid_q,    wvalid_d;
  logic            aw_done_q,   aw_done_d;
  logic            w_done_q,    w_done_d;
  logic            bready_q,    bready_d;
  logic            arvalid_q,   arvalid_d;
  logic            rready_q,    rready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [AW-1:0]   awaddr_q,    awaddr_d;
  logic [DW-1:0]   wdata_q,     wdata_d;
  logic [SW-1:0]   wstrb_q,     wstrb_d;
  logic [AW-1:0]   araddr_q,    araddr_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q,  rsp_resp_d;
  logic            rsp_write_q, rsp_write_d;
  logic [15:0]     err_cnt_q,   err_cnt_d;

  // Handshakes on this cycle, seen from the registered VALID/READY outputs.
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_done_now, w_done_now;

  assign aw_hs = awvalid_q & M_AXI_AWREADY;
  assign w_hs  = wvalid_q  & M_AXI_WREADY;
  assign b_hs  = bready_q  & M_AXI_BVALID;
  assign ar_hs = arvalid_q & M_AXI_ARREADY;
  assign r_hs  = rready_q  & M_AXI_RVALID;

  // A channel counts as done if it finished earlier or finishes this cycle, so
  // AW and W may complete in either order or together.
  assign aw_done_now = aw_done_q | aw_hs;
  assign w_done_now  = w_done_q  | w_hs;

  // Next state and next outputs. Every output is a flop loaded from here, so
  // no VALID can ever follow a READY input combinationally.
  always_comb begin
    // NOTE: every signal written below gets its hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    cmd_write_d = cmd_write_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    araddr_d    = araddr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_write_d = rsp_write_q;
    err_cnt_d   = err_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (CMD_VALID && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          cmd_write_d = CMD_WRITE;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          if (CMD_WRITE) begin
            awaddr_d  = CMD_ADDR;
            wdata_d   = CMD_WDATA;
            wstrb_d   = CMD_WSTRB;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_REQ;
          end else begin
            araddr_d  = CMD_ADDR;
            arvalid_d = 1'b1;
            state_d   = S_RD_REQ;
          end
        end
      end

      S_WR_REQ: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        aw_done_d = aw_done_now;
        w_done_d  = w_done_now;
        if (aw_done_now && w_done_now) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end

      S_WR_RESP: begin
        if (b_hs) begin
          bready_d    = 1'b0;
          rsp_rdata_d = '0;
          rsp_resp_d  = M_AXI_BRESP;
          rsp_write_d = cmd_write_q;
          rsp_valid_d = 1'b1;
          if (M_AXI_BRESP != 2'b00 && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          state_d = S_RSP;
        end
      end

      S_RD_REQ: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end

      S_RD_DATA: begin
        if (r_hs) begin
          rready_d    = 1'b0;
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
          rsp_write_d = cmd_write_q;
          rsp_valid_d = 1'b1;
          if (M_AXI_RRESP != 2'b00 && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          state_d = S_RSP;
        end
      end

      S_RSP: begin
        // Payload is untouched here, so it stays stable while RSP_VALID waits.
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    // NOTE: datapath registers are cleared by reset as well as control, since
    // the address/data outputs and the response payload must read 0 after it.
    if (M_AXI_ARESET) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      cmd_write_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      araddr_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      rsp_write_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // values, whatever order these statements are written in.
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_write_q <= cmd_write_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      araddr_q    <= araddr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_write_q <= rsp_write_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign CMD_READY     = cmd_ready_q;
  assign RSP_VALID     = rsp_valid_q;
  assign RSP_RDATA     = rsp_rdata_q;
  assign RSP_RESP      = rsp_resp_q;
  assign RSP_WRITE     = rsp_write_q;
  assign ERR_COUNT     = err_cnt_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_m_axi_lite_cmd.sv
// -----------------------------------------------------------------------------
// tb_m_axi_lite_cmd
//   Self-checking bench for m_axi_lite_cmd. Each transaction is described by
//   the slave's wait counts. The expected waveform of every output is worked out
//   from those counts as a timeline (the cycle on which each VALID/READY rises
//   and falls, and when the response and error count update). It is compared
//   with the DUT on every cycle at the falling clock edge. Directed cases come
//   first, then randomized commands.
// -----------------------------------------------------------------------------
module tb_m_axi_lite_cmd;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int SW = DW / 8;

  logic          clk;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_write;
  logic [15:0]   err_count;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_err = 16'd0;

  m_axi_lite_cmd #(
    .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_ADDR_WIDTH(AW)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESET (rst),
    .CMD_VALID    (cmd_valid),
    .CMD_READY    (cmd_ready),
    .CMD_WRITE    (cmd_write),
    .CMD_ADDR     (cmd_addr),
    .CMD_WDATA    (cmd_wdata),
    .CMD_WSTRB    (cmd_wstrb),
    .RSP_VALID    (rsp_valid),
    .RSP_READY    (rsp_ready),
    .RSP_RDATA    (rsp_rdata),
    .RSP_RESP     (rsp_resp),
    .RSP_WRITE    (rsp_write),
    .ERR_COUNT    (err_count),
    .M_AXI_AWADDR (awaddr),
    .M_AXI_AWPROT (awprot),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA  (wdata),
    .M_AXI_WSTRB  (wstrb),
    .M_AXI_WVALID (wvalid),
    .M_AXI_WREADY (wready),
    .M_AXI_BRESP  (bresp),
    .M_AXI_BVALID (bvalid),
    .M_AXI_BREADY (bready),
    .M_AXI_ARADDR (araddr),
    .M_AXI_ARPROT (arprot),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA  (rdata),
    .M_AXI_RRESP  (rresp),
    .M_AXI_RVALID (rvalid),
    .M_AXI_RREADY (rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic slave_idle();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
    rsp_ready = 1'b0;
  endtask

  // Runs one command. It is called at a falling edge with the DUT idle; that
  // clock cycle is cycle 0, the accept cycle.
  //   da/dw : wait cycles before AWREADY (or ARREADY) / WREADY
  //   db    : cycles BREADY/RREADY waits before BVALID/RVALID
  //   hold  : cycles RSP_VALID waits before RSP_READY
  //   rst_at: if nonzero, reset is applied at the end of that cycle
  // Returns the first cycle of RSP_VALID and of BREADY/RREADY (-1 if never
  // seen) and the response payload seen on the first RSP_VALID cycle.
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [SW-1:0] strb, input int da, input int dw, input int db,
                         input logic [1:0] resp, input logic [DW-1:0] rd_val, input int hold,
                         input int rst_at, output int rsp_cyc, output int rdy_cyc,
                         output logic [DW-1:0] obs_rdata, output logic [1:0] obs_resp);
    int          m, rspv, last;
    logic [15:0] err_after;
    bit          e_awv, e_wv, e_br, e_arv, e_rr, e_rspv;

    m         = (wr && dw > da) ? dw : da;   // the request phase ends on the later channel
    rspv      = 3 + m + db;                  // first cycle with RSP_VALID
    last      = rspv + hold + 1;             // back in IDLE
    err_after = (resp != 2'b00 && exp_err != 16'hFFFF) ? exp_err + 16'd1 : exp_err;
    rsp_cyc   = -1;
    rdy_cyc   = -1;
    obs_rdata = '0;
    obs_resp  = '0;

    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
    check("cmd_ready_accept", cmd_ready, 1);

    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      // The command must already be registered, so the port carries junk now.
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_wdata = $urandom;
      cmd_wstrb = SW'($urandom);

      if (rst_at != 0 && c == rst_at + 1) begin
        check("rst_awvalid",   awvalid,   0);
        check("rst_wvalid",    wvalid,    0);
        check("rst_bready",    bready,    0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_err_count", err_count, 0);
        check("rst_awaddr",    awaddr,    0);
        check("rst_wdata",     wdata,     0);
        check("rst_wstrb",     wstrb,     0);
        rst = 1'b0;
        exp_err = 16'd0;
        slave_idle();
        return;
      end

      if (rsp_cyc < 0 && rsp_valid === 1'b1) begin
        rsp_cyc   = c;
        obs_rdata = rsp_rdata;
        obs_resp  = rsp_resp;
      end
      if (rdy_cyc < 0 && (bready === 1'b1 || rready === 1'b1)) rdy_cyc = c;

      e_awv  = wr  && c <= 1 + da;
      e_wv   = wr  && c <= 1 + dw;
      e_br   = wr  && c >= 2 + m && c <= 2 + m + db;
      e_arv  = !wr && c <= 1 + da;
      e_rr   = !wr && c >= 2 + m && c <= 2 + m + db;
      e_rspv = c >= rspv && c <= rspv + hold;

      check("awvalid",   awvalid,   e_awv);
      check("wvalid",    wvalid,    e_wv);
      check("bready",    bready,    e_br);
      check("arvalid",   arvalid,   e_arv);
      check("rready",    rready,    e_rr);
      check("rsp_valid", rsp_valid, e_rspv);
      check("cmd_ready", cmd_ready, c == last);
      check("err_count", err_count, (c >= rspv) ? err_after : exp_err);
      check("awprot",    awprot,    0);
      check("arprot",    arprot,    0);
      if (e_awv) check("awaddr", awaddr, addr);
      if (e_wv) begin
        check("wdata", wdata, data);
        check("wstrb", wstrb, strb);
      end
      if (e_arv) check("araddr", araddr, addr);
      if (e_rspv) begin
        check("rsp_rdata", rsp_rdata, wr ? '0 : rd_val);
        check("rsp_resp",  rsp_resp,  resp);
        check("rsp_write", rsp_write, wr);
      end

      // Slave and response-port stimulus for this cycle.
      awready   = wr  && c == 1 + da;
      wready    = wr  && c == 1 + dw;
      bvalid    = wr  && c == 2 + m + db;
      bresp     = resp;
      arready   = !wr && c == 1 + da;
      rvalid    = !wr && c == 2 + m + db;
      rresp     = resp;
      rdata     = rd_val;
      rsp_ready = (c == rspv + hold);
      if (rst_at != 0 && c == rst_at) rst = 1'b1;
    end
    exp_err = err_after;
  endtask

  initial begin
    int            rc, bc;
    logic [DW-1:0] od;
    logic [1:0]    orp;

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    slave_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_awvalid",   awvalid,   0);
    check("reset_wvalid",    wvalid,    0);
    check("reset_bready",    bready,    0);
    check("reset_arvalid",   arvalid,   0);
    check("reset_rready",    rready,    0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_rsp_resp",  rsp_resp,  0);
    check("reset_rsp_write", rsp_write, 0);
    check("reset_err_count", err_count, 0);
    check("reset_awaddr",    awaddr,    0);
    check("reset_wdata",     wdata,     0);
    check("reset_wstrb",     wstrb,     0);
    check("reset_araddr",    araddr,    0);

    // Zero-wait write: AW/W at cycle 1, BREADY at 2, RSP_VALID at 3.
    run_txn(1, 12'h010, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 2'b00, '0, 0, 0, rc, bc, od, orp);
    check("t_write_rsp_cycle",    rc,  3);
    check("t_write_bready_cycle", bc,  2);
    check("t_write_resp",         orp, 2'b00);
    check("t_write_rdata",        od,  0);

    // Skewed write: AWREADY at cycle 1, WREADY at cycle 4, BREADY first at 5.
    run_txn(1, 12'h024, 32'h01234567, 4'h3, 0, 3, 0, 2'b00, '0, 0, 0, rc, bc, od, orp);
    check("t_skew_bready_cycle", bc, 5);
    check("t_skew_rsp_cycle",    rc, 6);

    // Read with two slave wait cycles on R.
    run_txn(0, 12'h040, '0, '0, 0, 0, 2, 2'b00, 32'hDEADBEEF, 0, 0, rc, bc, od, orp);
    check("t_read_rdata",     od,        32'hDEADBEEF);
    check("t_read_rsp_cycle", rc,        5);
    check("t_read_err_count", err_count, 0);

    // Error responses: read SLVERR, then write DECERR.
    run_txn(0, 12'h044, '0, '0, 1, 0, 0, 2'b10, 32'h0BADF00D, 0, 0, rc, bc, od, orp);
    check("t_err_read_resp", orp, 2'b10);
    run_txn(1, 12'h048, 32'h5A5A5A5A, 4'h1, 0, 1, 1, 2'b11, '0, 0, 0, rc, bc, od, orp);
    check("t_err_write_resp", orp,       2'b11);
    check("t_err_count_2",    err_count, 2);

    // Response backpressure: RSP_READY low for 10 cycles.
    run_txn(0, 12'h050, '0, '0, 0, 0, 0, 2'b00, 32'hCAFEF00D, 10, 0, rc, bc, od, orp);
    check("t_bp_rsp_cycle", rc, 3);
    check("t_bp_rdata",     od, 32'hCAFEF00D);

    // Reset while AWVALID is high (slave stalls AW/W for 5 cycles).
    run_txn(1, 12'h060, 32'hFFFF0000, 4'hC, 5, 5, 0, 2'b00, '0, 0, 2, rc, bc, od, orp);
    // Recovery after reset.
    run_txn(1, 12'h064, 32'h11112222, 4'hF, 0, 0, 0, 2'b10, '0, 0, 0, rc, bc, od, orp);
    check("t_post_rst_err_count", err_count, 1);

    // Randomized commands.
    for (int i = 0; i < 40; i++) begin
      bit            wr;
      logic [1:0]    rsp_code;
      wr       = 1'($urandom);
      rsp_code = 2'($urandom);
      run_txn(wr, AW'($urandom), $urandom, SW'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              rsp_code, $urandom, int'($urandom_range(0, 3)), 0, rc, bc, od, orp);
      check("rand_resp", orp, rsp_code);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a hang anywhere in the sequence.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
